// File: rtl/fetch_pc_ctrl_pkg.sv
// fetch_pc_ctrl_pkg: shared types and constants for the fetch PC sequencer.
// Holds the PC width, reset PC, FSM state encodings and the widths of the
// csr->preif and id->preif redirect buses.
package fetch_pc_ctrl_pkg;

   localparam int PC_WIDTH = 32;

   localparam logic [PC_WIDTH-1:0] FETCH_RESET_PC = 32'h1C00_0000;

   // csr->preif carries {excep_en, excep_pc, ertn_en, ertn_pc}
   localparam int CSR_TO_PREIF_W = 2 + 2 * PC_WIDTH;

   // id->preif carries {branch_flag, branch_pc}
   localparam int ID_TO_PREIF_W = 1 + PC_WIDTH;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/fetch_redirect_arb.sv
// fetch_redirect_arb: combinational priority select between the redirect
// sources (exception > ertn > branch/pending). Produces the target PC,
// whether pc_q takes it this cycle, the IF flush, and whether a branch
// must be latched because IF is stalled.
module fetch_redirect_arb
   import fetch_pc_ctrl_pkg::*;
#(
   parameter int PC_W = PC_WIDTH
) (
   input  state_t          state,
   input  logic            if_allowin,
   input  logic            excep_en,
   input  logic [PC_W-1:0] excep_pc,
   input  logic            ertn_en,
   input  logic [PC_W-1:0] ertn_pc,
   input  logic            branch_flag,
   input  logic [PC_W-1:0] branch_pc,
   input  logic [PC_W-1:0] pend_pc,
   output logic [PC_W-1:0] target,
   output logic            redirect_taken,
   output logic            flush,
   output logic            latch_branch
);

   // Exception and ertn win unconditionally; a branch is applied only when
   // IF can take the new PC, otherwise it is latched for HOLD.
   always_comb begin
      target         = pend_pc;
      redirect_taken = 1'b0;
      flush          = 1'b0;
      latch_branch   = 1'b0;
      if (excep_en) begin
         target         = excep_pc;
         redirect_taken = 1'b1;
         flush          = 1'b1;
      end else if (ertn_en) begin
         target         = ertn_pc;
         redirect_taken = 1'b1;
         flush          = 1'b1;
      end else if (state == ST_HOLD) begin
         if (if_allowin) begin
            target         = branch_flag ? branch_pc : pend_pc;
            redirect_taken = 1'b1;
            flush          = 1'b1;
         end else if (branch_flag) begin
            target       = branch_pc;
            latch_branch = 1'b1;
         end
      end else if (branch_flag) begin
         target = branch_pc;
         if (if_allowin) begin
            redirect_taken = 1'b1;
            flush          = 1'b1;
         end else begin
            latch_branch = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// fetch_pc_ctrl: fetch PC sequencer feeding the IF stage with a PC pair
// (pc1, pc1+4). Owns pc_q, holds a branch that arrives while IF is stalled,
// and arbitrates exception / ertn / branch redirects.
// Optional macro FETCH_LINE_GUARD_EN: when defined, the second slot is
// dropped whenever pc1 is the last word of a 16-byte fetch line.
module fetch_pc_ctrl
   import fetch_pc_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
   parameter int          PC_W     = PC_WIDTH
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_allowin_i,
   output logic            preif_valid_o,
   input  logic            excep_en_i,
   input  logic [PC_W-1:0] excep_pc_i,
   input  logic            ertn_en_i,
   input  logic [PC_W-1:0] ertn_pc_i,
   input  logic            branch_flag_i,
   input  logic [PC_W-1:0] branch_pc_i,
   output logic [PC_W-1:0] pc1_o,
   output logic [PC_W-1:0] pc2_o,
   output logic            pc2_valid_o,
   output logic            flush_if_o,
   output logic            redirect_pending_o
);

   state_t          state_q;
   state_t          state_d;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pend_pc_q;
   logic [PC_W-1:0] target;
   logic            redirect_taken;
   logic            latch_branch;
   logic [PC_W-1:0] advance;

   fetch_redirect_arb #(
      .PC_W(PC_W)
   ) u_arb (
      .state          (state_q),
      .if_allowin     (if_allowin_i),
      .excep_en       (excep_en_i),
      .excep_pc       (excep_pc_i),
      .ertn_en        (ertn_en_i),
      .ertn_pc        (ertn_pc_i),
      .branch_flag    (branch_flag_i),
      .branch_pc      (branch_pc_i),
      .pend_pc        (pend_pc_q),
      .target         (target),
      .redirect_taken (redirect_taken),
      .flush          (flush_if_o),
      .latch_branch   (latch_branch)
   );

   assign pc1_o = pc_q;
   assign pc2_o = pc_q + PC_W'(4);

`ifdef FETCH_LINE_GUARD_EN
   assign pc2_valid_o = (pc_q[3:2] != 2'b11);
`else
   assign pc2_valid_o = 1'b1;
`endif

   assign advance = pc2_valid_o ? PC_W'(8) : PC_W'(4);

   // FSM state register; reset always restarts in BOOT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: any taken redirect returns to RUN, a stalled branch parks in HOLD.
   always_comb begin
      state_d = state_q;
      if (redirect_taken) begin
         state_d = ST_RUN;
      end else if (latch_branch) begin
         state_d = ST_HOLD;
      end else begin
         case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            ST_HOLD: state_d = ST_HOLD;
            default: state_d = ST_BOOT;
         endcase
      end
   end

   // Outputs: only RUN offers a PC pair; HOLD advertises the latched branch.
   always_comb begin
      preif_valid_o      = 1'b0;
      redirect_pending_o = 1'b0;
      case (state_q)
         ST_RUN:  preif_valid_o      = 1'b1;
         ST_HOLD: redirect_pending_o = 1'b1;
         default: begin
            preif_valid_o      = 1'b0;
            redirect_pending_o = 1'b0;
         end
      endcase
   end

   // PC and pending-target registers: redirect, sequential advance on a
   // handshake, or hold; the pending target dies once any redirect lands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q      <= RESET_PC[PC_W-1:0];
         pend_pc_q <= '0;
      end else begin
         if (redirect_taken) begin
            pc_q      <= target;
            pend_pc_q <= '0;
         end else begin
            if (latch_branch) begin
               pend_pc_q <= target;
            end
            if (state_q == ST_RUN && if_allowin_i) begin
               pc_q <= pc_q + advance;
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// tb_fetch_pc_ctrl: directed bench for fetch_pc_ctrl with hand-computed
// expectations. Inputs change on the falling edge; outputs are checked
// on the falling edge (registered values) and shortly after input changes
// (combinational flush). Expectations follow FETCH_LINE_GUARD_EN if defined.
module tb_fetch_pc_ctrl;

   logic        clk;
   logic        rst;
   logic        if_allowin_i;
   logic        preif_valid_o;
   logic        excep_en_i;
   logic [31:0] excep_pc_i;
   logic        ertn_en_i;
   logic [31:0] ertn_pc_i;
   logic        branch_flag_i;
   logic [31:0] branch_pc_i;
   logic [31:0] pc1_o;
   logic [31:0] pc2_o;
   logic        pc2_valid_o;
   logic        flush_if_o;
   logic        redirect_pending_o;

   int num_checks;
   int num_fail;

   fetch_pc_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .if_allowin_i       (if_allowin_i),
      .preif_valid_o      (preif_valid_o),
      .excep_en_i         (excep_en_i),
      .excep_pc_i         (excep_pc_i),
      .ertn_en_i          (ertn_en_i),
      .ertn_pc_i          (ertn_pc_i),
      .branch_flag_i      (branch_flag_i),
      .branch_pc_i        (branch_pc_i),
      .pc1_o              (pc1_o),
      .pc2_o              (pc2_o),
      .pc2_valid_o        (pc2_valid_o),
      .flush_if_o         (flush_if_o),
      .redirect_pending_o (redirect_pending_o)
   );

   // 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      assert (obs === exp)
      else begin
         num_fail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic allowin,
                                 input logic ex_en, input logic [31:0] ex_pc,
                                 input logic er_en, input logic [31:0] er_pc,
                                 input logic br, input logic [31:0] br_pc);
      if_allowin_i  = allowin;
      excep_en_i    = ex_en;
      excep_pc_i    = ex_pc;
      ertn_en_i     = er_en;
      ertn_pc_i     = er_pc;
      branch_flag_i = br;
      branch_pc_i   = br_pc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      num_checks = 0;
      num_fail   = 0;
      rst = 1'b1;
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      #2;
      check_output("rst_preif_valid", {31'b0, preif_valid_o}, 32'd0);
      check_output("rst_flush", {31'b0, flush_if_o}, 32'd0);
      check_output("rst_pending", {31'b0, redirect_pending_o}, 32'd0);
      check_output("rst_pc2_valid", {31'b0, pc2_valid_o}, 32'd1);
      check_output("rst_pc1", pc1_o, 32'h1C00_0000);

      // Release reset; one BOOT cycle then sequential fetch.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_output("boot_preif_valid", {31'b0, preif_valid_o}, 32'd0);
      tick();
      check_output("seq0_pc1", pc1_o, 32'h1C00_0000);
      check_output("seq0_pc2", pc2_o, 32'h1C00_0004);
      check_output("seq0_valid", {31'b0, preif_valid_o}, 32'd1);
      tick();
      check_output("seq1_pc1", pc1_o, 32'h1C00_0008);
      tick();
      check_output("seq2_pc1", pc1_o, 32'h1C00_0010);
      check_output("seq2_pc2", pc2_o, 32'h1C00_0014);

      // Branch pulse while IF stalled: latched into HOLD.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0100);
      check_output("br_stall_flush", {31'b0, flush_if_o}, 32'd0);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         check_output("hold_pending", {31'b0, redirect_pending_o}, 32'd1);
         check_output("hold_preif_valid", {31'b0, preif_valid_o}, 32'd0);
         check_output("hold_pc1", pc1_o, 32'h1C00_0010);
         tick();
      end
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("hold_release_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      check_output("br_target_pc1", pc1_o, 32'h1C00_0100);
      check_output("br_target_valid", {31'b0, preif_valid_o}, 32'd1);
      check_output("br_target_pending", {31'b0, redirect_pending_o}, 32'd0);

      // Exception while HOLD: pending discarded.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0200);
      tick();
      apply_stimulus(1'b0, 1'b1, 32'h1C00_8000, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("ex_hold_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("ex_hold_pc1", pc1_o, 32'h1C00_8000);
      check_output("ex_hold_pending", {31'b0, redirect_pending_o}, 32'd0);
      check_output("ex_hold_valid", {31'b0, preif_valid_o}, 32'd1);
      tick();
      check_output("stall_hold_pc1", pc1_o, 32'h1C00_8000);
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_output("ex_after_pc1", pc1_o, 32'h1C00_8008);

      // All three redirects at once: exception wins.
      apply_stimulus(1'b1, 1'b1, 32'h1C00_A000, 1'b1, 32'h1C00_B000, 1'b1, 32'h1C00_C000);
      check_output("prio_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      check_output("prio_pc1", pc1_o, 32'h1C00_A000);

      // ertn beats branch, accepted even with IF stalled.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1C00_B000, 1'b1, 32'h1C00_C000);
      check_output("ertn_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      check_output("ertn_pc1", pc1_o, 32'h1C00_B000);
      check_output("ertn_pending", {31'b0, redirect_pending_o}, 32'd0);

      // Branch into the last word of a fetch line.
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_000C);
      check_output("br_run_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("line_pc1", pc1_o, 32'h1C00_000C);
      check_output("line_pc2", pc2_o, 32'h1C00_0010);
`ifdef FETCH_LINE_GUARD_EN
      check_output("line_pc2_valid", {31'b0, pc2_valid_o}, 32'd0);
      tick();
      check_output("line_next_pc1", pc1_o, 32'h1C00_0010);
`else
      check_output("line_pc2_valid", {31'b0, pc2_valid_o}, 32'd1);
      tick();
      check_output("line_next_pc1", pc1_o, 32'h1C00_0014);
`endif
      check_output("line_next_pc2_valid", {31'b0, pc2_valid_o}, 32'd1);

      // Wraparound at the top of the address space.
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("wrap_pre_pc1", pc1_o, 32'hFFFF_FFF8);
      tick();
      check_output("wrap8_pc1", pc1_o, 32'h0000_0000);
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
`ifdef FETCH_LINE_GUARD_EN
      check_output("wrapc_pc1", pc1_o, 32'h0000_0000);
`else
      check_output("wrapc_pc1", pc1_o, 32'h0000_0004);
`endif

      // HOLD: second branch overwrites pending target.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0300);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0400);
      check_output("overwrite_flush", {31'b0, flush_if_o}, 32'd0);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_output("overwrite_pc1", pc1_o, 32'h1C00_0400);

      // HOLD released by a cycle that also carries a new branch.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0300);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0500);
      check_output("release_br_flush", {31'b0, flush_if_o}, 32'd1);
      tick();
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("release_br_pc1", pc1_o, 32'h1C00_0500);

      // Asynchronous reset in the middle of HOLD.
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1C00_0600);
      tick();
      apply_stimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check_output("pre_rst_pending", {31'b0, redirect_pending_o}, 32'd1);
      rst = 1'b1;
      #1;
      check_output("async_rst_pc1", pc1_o, 32'h1C00_0000);
      check_output("async_rst_pending", {31'b0, redirect_pending_o}, 32'd0);
      check_output("async_rst_valid", {31'b0, preif_valid_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      tick();
      check_output("restart_pc1", pc1_o, 32'h1C00_0000);
      check_output("restart_valid", {31'b0, preif_valid_o}, 32'd1);
      tick();
      check_output("restart_next_pc1", pc1_o, 32'h1C00_0008);

      $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch PC sequencer in front of the instruction-fetch stage of the dual-issue LoongArch pipeline. Owns the architectural fetch PC register. Arbitrates the redirect sources (exception entry, ertn return, ID-stage branch) and holds a branch redirect that arrives while IF is stalled, so a one-cycle branch pulse is never lost. Presents a PC pair (pc1, pc1+4) to IF with a valid/allowin handshake.

## Interface
- `RESET_PC`, default 32'h1C00_0000: fetch PC after reset.
- `PC_W`, default 32: PC width.

Ports (all PCs are `PC_W` wide):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `if_allowin_i`  in  1  IF accepts a PC pair this cycle.
- `preif_valid_o`  out  1  `pc1_o`/`pc2_o` are valid for IF.
- `excep_en_i`  in  1  exception redirect request, single-cycle pulse.
- `excep_pc_i`  in  PC_W  exception entry PC.
- `ertn_en_i`  in  1  ertn redirect request, single-cycle pulse.
- `ertn_pc_i`  in  PC_W  ertn return PC.
- `branch_flag_i`  in  1  ID-stage taken-branch redirect, may be a single-cycle pulse.
- `branch_pc_i`  in  PC_W  branch target.
- `pc1_o`  out  PC_W  first fetch PC.
- `pc2_o`  out  PC_W  second fetch PC, always `pc1_o + 4`.
- `pc2_valid_o`  out  1  second slot valid.
- `flush_if_o`  out  1  kill the instruction(s) currently held in IF.
- `redirect_pending_o`  out  1  a branch redirect is latched and not yet applied.

## Operation
- States:
  - BOOT: reset state, one cycle, `preif_valid_o` = 0.
  - RUN.
  - HOLD: branch latched.
- Registers: `pc_q`, `pend_pc_q`, `state_q`.
- `pc1_o` = `pc_q`.
- `preif_valid_o` = 1 only in RUN.
- Priority each cycle: excep > ertn > branch/pending > sequential.
- `excep_en_i` (any state):
  - `pc_q` <= `excep_pc_i`; state -> RUN; pending cleared.
  - `flush_if_o` = 1.
  - Accepted regardless of `if_allowin_i`.
- `ertn_en_i` with `excep_en_i` = 0: same as exception, using `ertn_pc_i`.
- `branch_flag_i` in RUN, no excep/ertn:
  - With `if_allowin_i` = 1: `pc_q` <= `branch_pc_i`, `flush_if_o` = 1.
  - With `if_allowin_i` = 0: `pend_pc_q` <= `branch_pc_i`, state -> HOLD, `flush_if_o` = 0.
- HOLD:
  - `redirect_pending_o` = 1 and `preif_valid_o` = 0; wrong-path `pc_q` is not offered.
  - A new `branch_flag_i` overwrites `pend_pc_q`.
  - First cycle with `if_allowin_i` = 1: `pc_q` <= `pend_pc_q` (or `branch_pc_i` if flagged that same cycle), `flush_if_o` = 1, state -> RUN.
- Sequential (RUN, `if_allowin_i` = 1, no redirect): `pc_q` <= `pc_q + (pc2_valid_o ? 8 : 4)`.
- RUN with `if_allowin_i` = 0 and no redirect: all state held.
- BOOT -> RUN unconditionally. A redirect during BOOT is applied as in RUN.
- Arithmetic: modulo 2^PC_W; 32'hFFFF_FFFC + 8 wraps to 32'h4. Low 2 PC bits are passed through unchanged; alignment faults are IF's job.

## Timing
- Reset (asynchronous assert):
  - `pc_q` = `RESET_PC`, `pend_pc_q` = 0, state = BOOT.
  - Outputs: `preif_valid_o` = 0, `flush_if_o` = 0, `redirect_pending_o` = 0, `pc2_valid_o` = 1, `pc1_o` = `RESET_PC`.
- Deassertion: BOOT lasts exactly one `clk` edge, then RUN.
- `flush_if_o` is combinational, in the same cycle as the accepted redirect.
- Redirect target appears on `pc1_o` one cycle after acceptance, with `preif_valid_o` = 1.
- Branch latency is 1 cycle if IF is allowing, else 1 cycle after the first `if_allowin_i` = 1.
- Handshake: a PC pair transfers on `preif_valid_o & if_allowin_i`. `pc_q` must not change while `preif_valid_o` = 1 and `if_allowin_i` = 0, except on an exception or ertn redirect.
- Reset mid-HOLD: pending is discarded and fetch restarts at `RESET_PC`.

## Configuration
- `FETCH_LINE_GUARD_EN`:
  - Defined: `pc2_valid_o` = 0 when `pc1_o[3:2]` == 2'b11, so the pair never crosses a 16-byte fetch line. Sequential advance is +4 in that case.
  - Undefined: `pc2_valid_o` is constant 1 and advance is always +8.

## Structure
- Shared package/header: PC width macro, `RESET_PC` constant, state encodings (BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2), and the bus widths for the csr->preif and id->preif buses.
- One sub-module is natural: `fetch_redirect_arb`, the purely combinational priority select producing target, redirect-taken and flush. The FSM and registers stay in `fetch_pc_ctrl`.

## Test plan
- Reset then `if_allowin_i` = 1 steady, guard undefined:
  - cycle 1: `preif_valid_o` = 0.
  - Then `pc1_o` = 1C000000, 1C000008, 1C000010; `pc2_o` = `pc1_o` + 4.
- Branch pulse to 1C000100 while `if_allowin_i` = 0 for 3 cycles:
  - `redirect_pending_o` = 1 and `preif_valid_o` = 0 for those cycles.
  - On allowin: `flush_if_o` = 1; next cycle `pc1_o` = 1C000100.
- In HOLD (pending 1C000100), `excep_en_i` with `excep_pc_i` = 1C008000:
  - `flush_if_o` = 1, pending cleared.
  - Next `pc1_o` = 1C008000, never 1C000100.
- `excep_en_i`, `ertn_en_i` and `branch_flag_i` in the same cycle: next `pc1_o` = `excep_pc_i`.
- `FETCH_LINE_GUARD_EN` defined, `branch_pc_i` = 1C00000C:
  - `pc2_valid_o` = 0.
  - Next `pc1_o` = 1C000010 with `pc2_valid_o` = 1.
- `pc_q` = FFFFFFF8, advance +8 -> `pc1_o` = 00000000. Assert `rst` asynchronously mid-HOLD -> `pc1_o` = 1C000000 immediately.
